// File: rtl/mod_dp_if.sv
// Handshake bundle between the modulo control unit and the mod_dp datapath.
//   state       : 2-bit control code (00 IDLE, 01 SUBTRACT, 10 RESULT, 11 reserved)
//   a, b        : dividend / divisor, captured while state is IDLE
//   temp        : registered signed trial difference rem - div
//   done        : operation finished, result/quotient valid
//   result      : remainder of the last completed operation
//   quotient    : quotient of the last completed operation
//   div_by_zero : last operation had a zero divisor
// master = control unit side, slave = datapath side.
interface mod_dp_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] temp;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] quotient;
  logic             div_by_zero;

  modport master (
    output state, a, b,
    input  temp, done, result, quotient, div_by_zero
  );

  modport slave (
    input  state, a, b,
    output temp, done, result, quotient, div_by_zero
  );
endinterface

// File: rtl/mod_dp.sv
// Iterative modulo/divide datapath: computes a mod b and a / b by repeated
// subtraction, one subtraction per clock, under control of an external
// state code.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every register
//   bus   : mod_dp_if slave port (state/a/b in; temp/done/result/quotient/
//           div_by_zero out)
module mod_dp #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  mod_dp_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SUB    = 2'b01,
    ST_RESULT = 2'b10,
    ST_RSVD   = 2'b11
  } state_e;

  // Operands are treated as WIDTH-1-bit unsigned so the difference can never
  // overflow and its MSB is always the true sign.
  function automatic logic [WIDTH-1:0] mask_msb(input logic [WIDTH-1:0] v);
    return {1'b0, v[WIDTH-2:0]};
  endfunction

  logic [WIDTH-1:0] rem_q,      rem_d;
  logic [WIDTH-1:0] div_q,      div_d;
  logic [WIDTH-1:0] qcnt_q,     qcnt_d;
  logic             fin_q,      fin_d;
  logic [WIDTH-1:0] temp_q,     temp_d;
  logic             done_q,     done_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic             dbz_q,      dbz_d;

  logic signed [WIDTH-1:0] diff;
  state_e                  st;

  assign st   = state_e'(bus.state);
  assign diff = $signed(rem_q - div_q);

  always_comb begin
    rem_d      = rem_q;
    div_d      = div_q;
    qcnt_d     = qcnt_q;
    fin_d      = fin_q;
    temp_d     = temp_q;
    done_d     = done_q;
    result_d   = result_q;
    quotient_d = quotient_q;
    dbz_d      = dbz_q;

    case (st)
      ST_IDLE: begin
        rem_d  = mask_msb(bus.a);
        div_d  = mask_msb(bus.b);
        qcnt_d = '0;
        fin_d  = 1'b0;
        done_d = 1'b0;
        temp_d = '0;
      end
      ST_SUB: begin
        if (!fin_q) begin
          if (div_q == '0) begin
            dbz_d      = 1'b1;
            result_d   = rem_q;
            quotient_d = '0;
            temp_d     = '1;
            done_d     = 1'b1;
            fin_d      = 1'b1;
          end else begin
            temp_d = diff;
            if (diff >= 0) begin
              rem_d  = diff;
              qcnt_d = qcnt_q + 1'b1;
            end else begin
              // First negative difference: rem already holds the remainder.
              result_d   = rem_q;
              quotient_d = qcnt_q;
              dbz_d      = 1'b0;
              done_d     = 1'b1;
              fin_d      = 1'b1;
            end
          end
        end
        // Once finished, everything holds and temp stays negative so the
        // control unit leaves SUBTRACT.
      end
      default: ; // RESULT and reserved code: hold all registers
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q      <= '0;
      div_q      <= '0;
      qcnt_q     <= '0;
      fin_q      <= 1'b0;
      temp_q     <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      quotient_q <= '0;
      dbz_q      <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      div_q      <= div_d;
      qcnt_q     <= qcnt_d;
      fin_q      <= fin_d;
      temp_q     <= temp_d;
      done_q     <= done_d;
      result_q   <= result_d;
      quotient_q <= quotient_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.temp        = temp_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.quotient    = quotient_q;
  assign bus.div_by_zero = dbz_q;

endmodule
